// File: rtl/serial_rx_16_if.sv
// Bundle of the serial-receiver signals.
//   Bit side : sin, sin_valid, sof, invert   (driven by the line sender)
//   Word side: out, out_valid, out_ready     (valid/ready handshake)
//   Status   : overrun (sticky drop flag), busy (partial word held)
// slave  = receiver view (the serial_rx_16 block)
// master = sender/consumer view (whatever surrounds the receiver)
interface serial_rx_16_if;
    logic        sin;
    logic        sin_valid;
    logic        sof;
    logic        invert;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        busy;

    modport slave (
        input  sin, sin_valid, sof, invert, out_ready,
        output out, out_valid, overrun, busy
    );

    modport master (
        output sin, sin_valid, sof, invert, out_ready,
        input  out, out_valid, overrun, busy
    );
endinterface

// File: rtl/serial_rx_16.sv
// serial_rx_16: deserialises a strobed bit stream into 16-bit words.
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus.sin/sin_valid/sof/invert : bit input, one bit per sin_valid cycle;
//                sof marks bit position 0, invert complements line data
//   bus.out/out_valid/out_ready  : completed word with valid/ready handshake
//   bus.overrun: sticky, a completed word was dropped (cleared by reset only)
//   bus.busy   : a partial word (1..15 bits) is held
// LSB_FIRST=1 puts the first received bit in word bit 0, else in bit 15.
module serial_rx_16 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_rx_16_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [15:0] shreg_q, shreg_d;
    logic [15:0] out_q, out_d;
    logic        out_valid_q, out_valid_d;
    logic        overrun_q, overrun_d;

    // Bit acceptance and word assembly
    logic        accept;
    logic        complete;
    logic        bit_val;
    logic [3:0]  slot;        // arrival index of the current bit
    logic [3:0]  bit_pos;     // word bit position that slot maps to
    logic [15:0] word_nxt;    // shift register contents including this bit
    logic        handshake;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shreg_d     = shreg_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        // In IDLE only an sof bit may start a word; in SHIFT every strobed
        // bit is taken, and an sof there restarts the word from slot 0.
        accept   = bus.sin_valid && ((state_q == SHIFT) || bus.sof);
        bit_val  = bus.sin ^ bus.invert;
        slot     = bus.sof ? 4'd0 : count_q;
        bit_pos  = LSB_FIRST ? slot : (4'd15 - slot);
        word_nxt = bus.sof ? 16'h0000 : shreg_q;
        word_nxt[bit_pos] = bit_val;
        complete = accept && (slot == 4'd15);

        handshake = out_valid_q && bus.out_ready;

        if (accept) begin
            if (complete) begin
                // Word finished: shift side returns to IDLE on the same edge
                // so the next word can start immediately.
                state_d = IDLE;
                count_d = 4'd0;
                shreg_d = 16'h0000;
            end else begin
                state_d = SHIFT;
                count_d = slot + 4'd1;
                shreg_d = word_nxt;
            end
        end

        // Output side: a completing word may replace a word being consumed
        // in the same cycle; otherwise a pending word wins and the new one
        // is dropped.
        if (complete) begin
            if (!out_valid_q || bus.out_ready) begin
                out_d       = word_nxt;
                out_valid_d = 1'b1;
            end else begin
                overrun_d   = 1'b1;
            end
        end else if (handshake) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= 4'd0;
            shreg_q     <= 16'h0000;
            out_q       <= 16'h0000;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shreg_q     <= shreg_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_rx_16.sv
module tb_serial_rx_16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sin = 1'b0, sin_valid = 1'b0, sof = 1'b0, invert = 1'b0, out_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_rx_16_if if_a ();
    serial_rx_16_if if_b ();

    assign if_a.sin = sin;  assign if_a.sin_valid = sin_valid;  assign if_a.sof = sof;
    assign if_a.invert = invert;  assign if_a.out_ready = out_ready;
    assign if_b.sin = sin;  assign if_b.sin_valid = sin_valid;  assign if_b.sof = sof;
    assign if_b.invert = invert;  assign if_b.out_ready = out_ready;

    serial_rx_16 #(.LSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    serial_rx_16 #(.LSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

    // Behavioural model: bits are kept in arrival order; the word is built
    // only at completion, by plain copy (LSB first) or reversal (MSB first).
    typedef struct {
        int          cnt;      // bits of the partial word held (0 = idle)
        logic [15:0] arr;      // arr[i] = i-th accepted bit value
        logic [15:0] out;
        logic        vld;
        logic        ov;
    } mdl_t;

    mdl_t ma, mb;

    function automatic void mdl_reset(output mdl_t m);
        m.cnt = 0; m.arr = '0; m.out = '0; m.vld = 1'b0; m.ov = 1'b0;
    endfunction

    function automatic void mdl_step(inout mdl_t m, input bit lsb);
        logic        done = 1'b0;
        logic [15:0] w = '0;
        logic        take_it;
        if (sin_valid) begin
            if (sof) m.cnt = 0;
            if (sof || m.cnt > 0) begin
                m.arr[m.cnt] = sin ^ invert;
                m.cnt = m.cnt + 1;
                if (m.cnt == 16) begin
                    done  = 1'b1;
                    m.cnt = 0;
                end
            end
        end
        if (done) begin
            for (int i = 0; i < 16; i++) w[lsb ? i : 15 - i] = m.arr[i];
            take_it = !m.vld || out_ready;
            if (take_it) begin
                m.out = w;
                m.vld = 1'b1;
            end else begin
                m.ov = 1'b1;
            end
        end else if (m.vld && out_ready) begin
            m.vld = 1'b0;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl_reset(ma);
        else        mdl_step(ma, 1'b1);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl_reset(mb);
        else        mdl_step(mb, 1'b0);
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare of both DUTs against the model
    always @(negedge clk) begin
        chk("a.out_valid", {15'd0, if_a.out_valid}, {15'd0, ma.vld});
        chk("a.busy",      {15'd0, if_a.busy},      {15'd0, ma.cnt > 0});
        chk("a.overrun",   {15'd0, if_a.overrun},   {15'd0, ma.ov});
        if (ma.vld) chk("a.out", if_a.out, ma.out);
        chk("b.out_valid", {15'd0, if_b.out_valid}, {15'd0, mb.vld});
        chk("b.busy",      {15'd0, if_b.busy},      {15'd0, mb.cnt > 0});
        chk("b.overrun",   {15'd0, if_b.overrun},   {15'd0, mb.ov});
        if (mb.vld) chk("b.out", if_b.out, mb.out);
    end

    task automatic idle(input int n);
        sin_valid = 1'b0; sof = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Sends n bits of w (first bit carries sof when with_sof), line data
    // complemented when inv, gap of (i % 6) idle cycles after bit i when
    // gapped, out_ready raised on the 16th bit when rdy_last.
    task automatic send_bits(input logic [15:0] w, input int n, input bit msb_first,
                             input bit inv, input bit with_sof, input bit gapped,
                             input bit rdy_last);
        for (int i = 0; i < n; i++) begin
            invert    = inv;
            sin       = w[msb_first ? 15 - i : i] ^ inv;
            sof       = with_sof && (i == 0);
            sin_valid = 1'b1;
            if (rdy_last && i == 15) out_ready = 1'b1;
            @(negedge clk);
            sin_valid = 1'b0; sof = 1'b0;
            if (gapped) repeat (i % 6) @(negedge clk);
        end
        invert = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.a.out", if_a.out, 16'h0000);
        chk("rst.a.vld", {15'd0, if_a.out_valid}, 16'd0);
        chk("rst.a.ov",  {15'd0, if_a.overrun}, 16'd0);
        chk("rst.b.busy", {15'd0, if_b.busy}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // A5C3 LSB first, valid for exactly one cycle
        out_ready = 1'b1;
        send_bits(16'hA5C3, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("a5c3.vld", {15'd0, if_a.out_valid}, 16'd1);
        chk("a5c3.out", if_a.out, 16'hA5C3);
        @(negedge clk);
        chk("a5c3.vld_drop", {15'd0, if_a.out_valid}, 16'd0);

        // Inverted line, both bit orders
        send_bits(16'h1234, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("inv_lsb.out", if_a.out, 16'h1234);
        idle(2);
        send_bits(16'h1234, 16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("inv_msb.out", if_b.out, 16'h1234);
        chk("inv_msb.vld", {15'd0, if_b.out_valid}, 16'd1);
        idle(2);

        // Overrun
        out_ready = 1'b0;
        send_bits(16'h0001, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ovr.first", if_a.out, 16'h0001);
        send_bits(16'hFFFF, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ovr.kept", if_a.out, 16'h0001);
        chk("ovr.flag", {15'd0, if_a.overrun}, 16'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("ovr.vld_drop", {15'd0, if_a.out_valid}, 16'd0);
        chk("ovr.sticky", {15'd0, if_a.overrun}, 16'd1);
        idle(2);
        do_reset();
        chk("ovr.rst_clear", {15'd0, if_a.overrun}, 16'd0);

        // Completion coincides with handshake of the prior word
        out_ready = 1'b0;
        send_bits(16'h00FF, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("hs.first", if_a.out, 16'h00FF);
        send_bits(16'hBEEF, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("hs.out", if_a.out, 16'hBEEF);
        chk("hs.vld", {15'd0, if_a.out_valid}, 16'd1);
        chk("hs.ov",  {15'd0, if_a.overrun}, 16'd0);
        @(negedge clk);
        chk("hs.vld_drop", {15'd0, if_a.out_valid}, 16'd0);

        // Partial word restarted by sof
        send_bits(16'h007F, 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("part.busy", {15'd0, if_a.busy}, 16'd1);
        send_bits(16'h8001, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("part.out", if_a.out, 16'h8001);
        chk("part.ov", {15'd0, if_a.overrun}, 16'd0);
        idle(2);

        // Partial word killed by reset; non-sof bits then ignored
        send_bits(16'h0055, 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("rstmid.busy", {15'd0, if_a.busy}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_bits(16'hFFFF, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstmid.ignored", {15'd0, if_a.busy}, 16'd0);

        // sof without sin_valid is ignored
        sof = 1'b1; @(negedge clk); sof = 1'b0;
        chk("sof_novalid.busy", {15'd0, if_a.busy}, 16'd0);

        // Gapped bits, discarded until sof, then a gapped word
        send_bits(16'hFFFF, 6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("gap.discard", {15'd0, if_a.busy}, 16'd0);
        send_bits(16'h6C71, 16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1);
        chk("gap.out", ma.out, 16'h6C71);
        send_bits(16'h6C71, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1);
        chk("gap.msb.out", mb.out, 16'h6C71);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
